noc_link_checker: RTL and testbench

Parametrised per-link NoC protocol and boundary checker for the manycore testbench. One instance is bound to one router output direction of one tile and covers all physical networks on that link. It tracks packet framing from the header length field and the valid/yummy credit balance per network. It flags links that must stay silent, credit protocol violations and oversized packets, and reports the first error with sticky capture, plus per-network packet counts.

---
 rtl/noc_link_checker_pkg.sv | 40 ++++
 rtl/noc_link_chan.sv | 110 +++++++++++
 rtl/noc_link_checker.sv | 119 +++++++++++
 tb/tb_noc_link_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_checker_pkg.sv
// Shared definitions for the NoC link checker: error codes, default header
// field positions, channel state type and the per-network error encoder.
package noc_link_checker_pkg;

  // Error codes reported on err_code_o
  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_BOUNDARY    = 3'd1;
  localparam logic [2:0] ERR_CREDIT_OVF  = 3'd2;
  localparam logic [2:0] ERR_CREDIT_UNF  = 3'd3;
  localparam logic [2:0] ERR_LEN_ILLEGAL = 3'd4;

  // Default header payload-length field position
  localparam int DEF_LEN_LSB   = 22;
  localparam int DEF_LEN_WIDTH = 8;

  // Bit positions inside the per-network error vector
  localparam int EV_BOUNDARY    = 0;
  localparam int EV_CREDIT_OVF  = 1;
  localparam int EV_LEN_ILLEGAL = 2;
  localparam int EV_CREDIT_UNF  = 3;

  // Framing state of one network
  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } chan_state_e;

  // Collapse one network's error vector to a single code.
  // Priority: BOUNDARY > CREDIT_OVF > LEN_ILLEGAL > CREDIT_UNF.
  function automatic logic [2:0] err_encode(input logic [3:0] ev);
    logic [2:0] code;
    code = ERR_NONE;
    if (ev[EV_BOUNDARY])         code = ERR_BOUNDARY;
    else if (ev[EV_CREDIT_OVF])  code = ERR_CREDIT_OVF;
    else if (ev[EV_LEN_ILLEGAL]) code = ERR_LEN_ILLEGAL;
    else if (ev[EV_CREDIT_UNF])  code = ERR_CREDIT_UNF;
    return code;
  endfunction

endpackage

// File: rtl/noc_link_chan.sv
// One physical network of a link: packet framing FSM, remaining-flit
// counter, valid/yummy credit balance, error detection and packet counter.
//
// Handshake: a flit is transferred in every cycle valid_i is high (no
// ready; flow control is by credits). Each flit consumes one credit and each
// yummy_i returns one. Framing and credit tracking run regardless of
// mon_en_i so that re-enabling mid-packet stays in sync; only error
// detection and packet counting are gated by mon_en_i.
module noc_link_chan
  import noc_link_checker_pkg::*;
#(
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int MAX_LEN   = 8,
  parameter int CREDITS   = 4,
  parameter bit LINK_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_en_i,
  input  logic                 valid_i,
  input  logic                 yummy_i,
  input  logic [LEN_WIDTH-1:0] hdr_len_i,
  output logic [3:0]           err_vec_o,
  output chan_state_e          state_o,
  output logic [31:0]          pkt_cnt_o
);

  localparam int                 CRED_W    = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0]  CRED_FULL = CRED_W'(CREDITS);
  localparam logic [LEN_WIDTH:0] MAX_LEN_W = (LEN_WIDTH + 1)'(MAX_LEN);

  chan_state_e          state_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic [CRED_W-1:0]    credit_q;
  logic [31:0]          pkt_cnt_q;

  logic cred_empty;
  logic cred_full;
  logic pkt_done;
  logic [3:0] err_vec;

  assign cred_empty = (credit_q == '0);
  assign cred_full  = (credit_q == CRED_FULL);

  // A packet completes on a zero-length header or on the last body flit
  assign pkt_done = valid_i &&
                    (((state_q == ST_HEAD) && (hdr_len_i == '0)) ||
                     ((state_q == ST_BODY) && (remaining_q == LEN_WIDTH'(1))));

  // Detect protocol violations on this network in the current cycle
  always_comb begin
    err_vec = '0;
    if (mon_en_i) begin
      err_vec[EV_BOUNDARY]    = valid_i && !LINK_EN;
      err_vec[EV_CREDIT_OVF]  = valid_i && cred_empty;
      err_vec[EV_LEN_ILLEGAL] = valid_i && (state_q == ST_HEAD) &&
                                ({1'b0, hdr_len_i} > MAX_LEN_W);
      err_vec[EV_CREDIT_UNF]  = yummy_i && cred_full;
    end
  end

  assign err_vec_o = err_vec;
  assign state_o   = state_q;
  assign pkt_cnt_o = pkt_cnt_q;

  // Framing FSM; illegal lengths are still framed so the checker keeps sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HEAD;
      remaining_q <= '0;
    end else if (valid_i) begin
      case (state_q)
        ST_HEAD: begin
          if (hdr_len_i != '0) begin
            state_q     <= ST_BODY;
            remaining_q <= hdr_len_i;
          end
        end
        ST_BODY: begin
          remaining_q <= remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_q <= ST_HEAD;
        end
        default: state_q <= ST_HEAD;
      endcase
    end
  end

  // Credit balance, clamped at both ends instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CRED_FULL;
    end else begin
      case ({valid_i, yummy_i})
        2'b10:   if (!cred_empty) credit_q <= credit_q - CRED_W'(1);
        2'b01:   if (!cred_full)  credit_q <= credit_q + CRED_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  // Saturating count of completed packets, frozen while monitoring is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (mon_en_i && pkt_done && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/noc_link_checker.sv
// Per-link NoC protocol and boundary checker. One channel per physical
// network; the top picks the highest-priority error (lowest network wins),
// pulses err_pulse_o on every new error and keeps a sticky capture of the
// first one until err_clr_i.
module noc_link_checker
  import noc_link_checker_pkg::*;
#(
  parameter int                  NUM_NOCS   = 3,
  parameter int                  DATA_WIDTH = 64,
  parameter int                  LEN_LSB    = DEF_LEN_LSB,
  parameter int                  LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int                  MAX_LEN    = 8,
  parameter int                  CREDITS    = 4,
  parameter logic [NUM_NOCS-1:0] LINK_EN    = {NUM_NOCS{1'b1}}
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               mon_en_i,
  input  logic                                               err_clr_i,
  input  logic [NUM_NOCS-1:0]                                valid_i,
  input  logic [NUM_NOCS*DATA_WIDTH-1:0]                     data_i,
  input  logic [NUM_NOCS-1:0]                                yummy_i,
  output logic                                               err_pulse_o,
  output logic                                               err_sticky_o,
  output logic [2:0]                                         err_code_o,
  output logic [((NUM_NOCS > 1) ? $clog2(NUM_NOCS) : 1)-1:0] err_noc_o,
  output logic [DATA_WIDTH-1:0]                              err_data_o,
  output logic [NUM_NOCS-1:0]                                busy_o,
  output logic [NUM_NOCS*32-1:0]                             pkt_cnt_o
);

  localparam int NOC_W = (NUM_NOCS > 1) ? $clog2(NUM_NOCS) : 1;

  logic [3:0]  chan_vec   [NUM_NOCS];
  logic [2:0]  chan_code  [NUM_NOCS];
  chan_state_e chan_state [NUM_NOCS];

  for (genvar n = 0; n < NUM_NOCS; n++) begin : g_chan
    noc_link_chan #(
      .LEN_WIDTH (LEN_WIDTH),
      .MAX_LEN   (MAX_LEN),
      .CREDITS   (CREDITS),
      .LINK_EN   (LINK_EN[n])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .mon_en_i  (mon_en_i),
      .valid_i   (valid_i[n]),
      .yummy_i   (yummy_i[n]),
      .hdr_len_i (data_i[n*DATA_WIDTH+LEN_LSB +: LEN_WIDTH]),
      .err_vec_o (chan_vec[n]),
      .state_o   (chan_state[n]),
      .pkt_cnt_o (pkt_cnt_o[n*32 +: 32])
    );

    assign chan_code[n] = err_encode(chan_vec[n]);
    assign busy_o[n]    = (chan_state[n] == ST_BODY);
  end

  logic                  sel_found;
  logic [2:0]            sel_code;
  logic [NOC_W-1:0]      sel_noc;
  logic [DATA_WIDTH-1:0] sel_data;

  // Cross-network priority: scan downwards so the lowest erroring network wins
  always_comb begin
    sel_found = 1'b0;
    sel_code  = ERR_NONE;
    sel_noc   = '0;
    sel_data  = '0;
    for (int n = NUM_NOCS - 1; n >= 0; n--) begin
      if (chan_code[n] != ERR_NONE) begin
        sel_found = 1'b1;
        sel_code  = chan_code[n];
        sel_noc   = NOC_W'(n);
        sel_data  = data_i[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic                  err_pulse_q;
  logic                  err_sticky_q;
  logic [2:0]            err_code_q;
  logic [NOC_W-1:0]      err_noc_q;
  logic [DATA_WIDTH-1:0] err_data_q;

  // Error pulse and sticky first-error capture; a clear in the same cycle as
  // a new error lets the new error be captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_noc_q    <= '0;
      err_data_q   <= '0;
    end else begin
      err_pulse_q <= sel_found;
      if (err_clr_i) begin
        err_sticky_q <= 1'b0;
        err_code_q   <= ERR_NONE;
        err_noc_q    <= '0;
        err_data_q   <= '0;
      end
      if (sel_found && (!err_sticky_q || err_clr_i)) begin
        err_sticky_q <= 1'b1;
        err_code_q   <= sel_code;
        err_noc_q    <= sel_noc;
        err_data_q   <= sel_data;
      end
    end
  end

  assign err_pulse_o  = err_pulse_q;
  assign err_sticky_o = err_sticky_q;
  assign err_code_o   = err_code_q;
  assign err_noc_o    = err_noc_q;
  assign err_data_o   = err_data_q;

endmodule

// File: tb/tb_noc_link_checker.sv
// Directed bench for noc_link_checker: three networks, network 1 disabled
// (LINK_EN = 3'b101), CREDITS = 4, MAX_LEN = 8, length field at [29:22].
module tb_noc_link_checker;

  localparam int NN = 3;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             mon_en;
  logic             err_clr;
  logic [NN-1:0]    valid;
  logic [NN*DW-1:0] data;
  logic [NN-1:0]    yummy;

  logic             err_pulse;
  logic             err_sticky;
  logic [2:0]       err_code;
  logic [1:0]       err_noc;
  logic [DW-1:0]    err_data;
  logic [NN-1:0]    busy;
  logic [NN*32-1:0] pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  noc_link_checker #(
    .NUM_NOCS   (NN),
    .DATA_WIDTH (DW),
    .LEN_LSB    (22),
    .LEN_WIDTH  (8),
    .MAX_LEN    (8),
    .CREDITS    (4),
    .LINK_EN    (3'b101)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mon_en_i     (mon_en),
    .err_clr_i    (err_clr),
    .valid_i      (valid),
    .data_i       (data),
    .yummy_i      (yummy),
    .err_pulse_o  (err_pulse),
    .err_sticky_o (err_sticky),
    .err_code_o   (err_code),
    .err_noc_o    (err_noc),
    .err_data_o   (err_data),
    .busy_o       (busy),
    .pkt_cnt_o    (pkt_cnt)
  );

  // ---------------- scoreboard / checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int len, input logic [15:0] tag);
    logic [63:0] h;
    h = 64'(tag);
    h[22 +: 8] = 8'(len);
    return h;
  endfunction

  function automatic logic [31:0] cnt(input int n);
    return pkt_cnt[n*32 +: 32];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    valid   = '0;
    yummy   = '0;
    err_clr = 1'b0;
    data    = '0;
  endtask

  task automatic flit(input int n, input logic [63:0] d);
    valid[n] = 1'b1;
    data[n*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    idle();
    err_clr = 1'b1;
    step();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mon_en = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pulse",  64'(err_pulse),  0);
    check_eq("rst_sticky", 64'(err_sticky), 0);
    check_eq("rst_code",   64'(err_code),   0);
    check_eq("rst_noc",    64'(err_noc),    0);
    check_eq("rst_data",   err_data,        0);
    check_eq("rst_busy",   64'(busy),       0);
    check_eq("rst_cnt0",   64'(cnt(0)),     0);
    check_eq("rst_cnt2",   64'(cnt(2)),     0);
    rst_n = 1'b1;
    step();

    // T1: len-2 packet on noc0, yummy returned after each flit
    idle(); flit(0, hdr(2, 16'h0001)); step();
    check_eq("t1_busy_hdr", 64'(busy), 64'b001);
    check_eq("t1_cnt_hdr",  64'(cnt(0)), 0);
    idle(); flit(0, 64'h1111); yummy[0] = 1'b1; step();
    check_eq("t1_busy_b1",  64'(busy), 64'b001);
    idle(); flit(0, 64'h2222); yummy[0] = 1'b1; step();
    check_eq("t1_busy_b2",  64'(busy), 64'b000);
    check_eq("t1_cnt_done", 64'(cnt(0)), 1);
    idle(); yummy[0] = 1'b1; step();
    check_eq("t1_no_pulse",  64'(err_pulse), 0);
    check_eq("t1_no_sticky", 64'(err_sticky), 0);

    // T2: valid on disabled noc1 is a boundary error
    idle(); flit(1, 64'hDEAD); step();
    check_eq("t2_pulse",  64'(err_pulse), 1);
    check_eq("t2_sticky", 64'(err_sticky), 1);
    check_eq("t2_code",   64'(err_code), 1);
    check_eq("t2_noc",    64'(err_noc), 1);
    check_eq("t2_data",   err_data, 64'hDEAD);
    idle(); step();
    check_eq("t2_pulse_end", 64'(err_pulse), 0);
    check_eq("t2_sticky_hold", 64'(err_sticky), 1);
    clear_err();
    check_eq("t2_clr_sticky", 64'(err_sticky), 0);
    check_eq("t2_clr_code",   64'(err_code), 0);
    check_eq("t2_clr_noc",    64'(err_noc), 0);
    check_eq("t2_clr_data",   err_data, 0);

    // T3: five header-only flits on noc2 without yummy -> overflow on fifth
    for (int i = 0; i < 5; i++) begin
      idle(); flit(2, hdr(0, 16'(i))); step();
      if (i < 4) check_eq("t3_no_err", 64'(err_pulse), 0);
    end
    check_eq("t3_pulse", 64'(err_pulse), 1);
    check_eq("t3_code",  64'(err_code), 2);
    check_eq("t3_noc",   64'(err_noc), 2);
    check_eq("t3_data",  err_data, hdr(0, 16'h0004));
    check_eq("t3_cnt",   64'(cnt(2)), 5);
    idle(); flit(2, hdr(0, 16'h0005)); step();
    check_eq("t3_pulse2",   64'(err_pulse), 1);
    check_eq("t3_code_keep", 64'(err_code), 2);
    check_eq("t3_data_keep", err_data, hdr(0, 16'h0004));
    clear_err();
    // credits held at 0: four yummies are legal, the fifth underflows
    for (int i = 0; i < 4; i++) begin
      idle(); yummy[2] = 1'b1; step();
      check_eq("t3_yummy_ok", 64'(err_pulse), 0);
    end
    idle(); yummy[2] = 1'b1; step();
    check_eq("t3_unf_pulse", 64'(err_pulse), 1);
    check_eq("t3_unf_code",  64'(err_code), 3);
    check_eq("t3_unf_noc",   64'(err_noc), 2);
    clear_err();

    // T4: len 9 > MAX_LEN is flagged but still framed over 9 body flits
    idle(); flit(0, hdr(9, 16'h0005)); step();
    check_eq("t4_pulse", 64'(err_pulse), 1);
    check_eq("t4_code",  64'(err_code), 4);
    check_eq("t4_noc",   64'(err_noc), 0);
    check_eq("t4_data",  err_data, hdr(9, 16'h0005));
    check_eq("t4_busy",  64'(busy), 64'b001);
    for (int i = 0; i < 9; i++) begin
      idle(); flit(0, '1); yummy[0] = 1'b1; step();
      check_eq("t4_body_no_err", 64'(err_pulse), 0);
      if (i < 8) check_eq("t4_body_busy", 64'(busy), 64'b001);
    end
    check_eq("t4_busy_end", 64'(busy), 64'b000);
    check_eq("t4_cnt",      64'(cnt(0)), 2);
    idle(); yummy[0] = 1'b1; step();
    check_eq("t4_credit_ret", 64'(err_pulse), 0);
    clear_err();

    // T5: lowest network wins even with a lower-priority code
    idle(); yummy[0] = 1'b1; data[0 +: DW] = 64'h1234; flit(1, 64'hBEEF); step();
    check_eq("t5_pulse", 64'(err_pulse), 1);
    check_eq("t5_code",  64'(err_code), 3);
    check_eq("t5_noc",   64'(err_noc), 0);
    check_eq("t5_data",  err_data, 64'h1234);
    idle(); flit(1, 64'h7777); step();
    check_eq("t5_later_pulse", 64'(err_pulse), 1);
    check_eq("t5_later_code",  64'(err_code), 3);
    check_eq("t5_later_noc",   64'(err_noc), 0);
    idle(); err_clr = 1'b1; flit(1, 64'hCAFE); step();
    check_eq("t5_clr_new_sticky", 64'(err_sticky), 1);
    check_eq("t5_clr_new_code",   64'(err_code), 1);
    check_eq("t5_clr_new_noc",    64'(err_noc), 1);
    check_eq("t5_clr_new_data",   err_data, 64'hCAFE);
    clear_err();
    // noc1 now has 0 credits: boundary beats overflow and illegal length
    idle(); flit(1, hdr(9, 16'h0000)); step();
    check_eq("t5_prio_bnd", 64'(err_code), 1);
    clear_err();
    // drain noc2, then an oversized header: overflow beats illegal length
    for (int i = 0; i < 4; i++) begin
      idle(); flit(2, hdr(0, 16'(i))); step();
    end
    check_eq("t5_drain_ok", 64'(err_sticky), 0);
    idle(); flit(2, hdr(9, 16'h00AA)); step();
    check_eq("t5_prio_ovf", 64'(err_code), 2);
    check_eq("t5_prio_noc", 64'(err_noc), 2);
    clear_err();

    // T6: mon_en low masks errors and freezes counters, tracking continues
    idle(); mon_en = 1'b0; yummy[0] = 1'b1; step();
    check_eq("t6_masked_unf", 64'(err_pulse), 0);
    idle(); flit(0, hdr(0, 16'h0001)); step();
    check_eq("t6_cnt_frozen", 64'(cnt(0)), 2);
    check_eq("t6_no_pulse",   64'(err_pulse), 0);
    mon_en = 1'b1;
    idle(); yummy[0] = 1'b1; step();
    check_eq("t6_credit_tracked", 64'(err_pulse), 0);
    idle(); yummy[0] = 1'b1; step();
    check_eq("t6_unf_after", 64'(err_code), 3);
    clear_err();

    // T7: asynchronous reset mid-packet
    check_eq("t7_busy_pre", 64'(busy), 64'b110);
    rst_n = 1'b0;
    #1;
    check_eq("t7_busy_rst",   64'(busy), 0);
    check_eq("t7_cnt_rst",    64'(cnt(2)), 0);
    check_eq("t7_sticky_rst", 64'(err_sticky), 0);
    step();
    rst_n = 1'b1;
    step();
    idle(); flit(2, hdr(0, 16'h0003)); step();
    check_eq("t7_hdr_busy", 64'(busy), 0);
    check_eq("t7_hdr_cnt",  64'(cnt(2)), 1);
    check_eq("t7_hdr_err",  64'(err_pulse), 0);
    idle(); yummy[2] = 1'b1; step();
    check_eq("t7_yummy_ok", 64'(err_pulse), 0);
    idle(); yummy[2] = 1'b1; step();
    check_eq("t7_unf_pulse", 64'(err_pulse), 1);
    check_eq("t7_unf_code",  64'(err_code), 3);
    idle();
    step();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
